// File: rtl/register_bank_pkg.sv
// Shared types and helpers for the Flurbie general-register file.
package register_bank_pkg;

  localparam int REG_W = 32;
  localparam int IDX_W = 5;

  typedef logic [IDX_W-1:0] regind_t;
  typedef logic [REG_W-1:0] regval_t;
  typedef logic [3:0]       flags_t;

  // Flags lives in the top register, the PC alias just below it.
  function automatic int flags_index(input int nr);
    return nr - 1;
  endfunction

  function automatic int pc_index(input int nr);
    return nr - 2;
  endfunction

  // Priority resolution of one read: hardwired zero, PC alias, forwarding,
  // write-through, and finally the stored array value.
  function automatic regval_t resolve_read(
    input regind_t idx,
    input regval_t pc,
    input logic    fb_hit,
    input regval_t fb_val,
    input logic    wr_hit,
    input regval_t wr_val,
    input regval_t arr_val,
    input int      nr
  );
    if (idx == '0 || int'(idx) >= nr) return '0;
    if (int'(idx) == pc_index(nr))    return pc;
    if (fb_hit)                       return fb_val;
    if (wr_hit)                       return wr_val;
    return arr_val;
  endfunction

endpackage

// File: rtl/register_bank_scoreboard.sv
// Load reservation scoreboard: one pending bit per register, set by issued
// memory reads, cleared by the committing write or a pipeline flush.
module register_bank_scoreboard
  import register_bank_pkg::*;
#(
  parameter int NR  = 32,
  parameter int NRP = 2
) (
  input  logic    clock,
  input  logic    reset_n,
  input  logic    wr_enable_i,
  input  regind_t wr_index_i,
  input  logic    wr_has_upper_i,
  input  logic    rsv_enable_i,
  input  regind_t rsv_index_i,
  input  logic    flush_i,
  input  logic    rd_enable_i [NRP],
  input  regind_t rd_index_i  [NRP],
  input  logic    bypass_i    [NRP],
  output logic    hold_o
);

  localparam int PC_IDX = pc_index(NR);

  logic [NR-1:0] pending_q, pending_d;

  // Next pending state: write clears first, a younger reservation then wins, flush overrides all.
  always_comb begin
    // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch is inferred.
    pending_d = pending_q;
    for (int r = 0; r < NR; r++) begin
      if (wr_enable_i && (int'(wr_index_i) == r ||
                          (wr_has_upper_i && int'(wr_index_i) + 1 == r)))
        pending_d[r] = 1'b0;
      if (rsv_enable_i && int'(rsv_index_i) == r && r != 0 && r != PC_IDX)
        pending_d[r] = 1'b1;
    end
    if (flush_i) pending_d = '0;
  end

  // Hold while any enabled port reads a pending register that nothing forwards.
  always_comb begin
    hold_o = 1'b0;
    for (int p = 0; p < NRP; p++)
      for (int r = 0; r < NR; r++)
        if (rd_enable_i[p] && !bypass_i[p] && int'(rd_index_i[p]) == r && pending_q[r])
          hold_o = 1'b1;
  end

  // Pending vector state.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) pending_q <= '0;
    else          pending_q <= pending_d;
  end

endmodule

// File: rtl/register_bank.sv
// Flurbie general-register file: NRP registered read ports with forwarding,
// a paired lower/upper write port, a flags write and a load scoreboard.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int NR  = 32,
  parameter int NRP = 2,
  parameter int NFB = 2
) (
  input  logic    clock,
  input  logic    reset_n,
  input  regval_t pc,
  input  logic    rd_enable      [NRP],
  input  regind_t rd_index       [NRP],
  output regval_t rd_value       [NRP],
  output logic    rd_valid,
  output logic    hold,
  input  logic    fb_is_valid    [NFB],
  input  regind_t fb_index       [NFB],
  input  regval_t fb_value       [NFB],
  input  logic    fb_has_upper   [NFB],
  input  regval_t fb_upper_value [NFB],
  input  logic    wr_enable,
  input  regind_t wr_index,
  input  regval_t wr_value,
  input  logic    wr_has_upper,
  input  regval_t wr_upper_value,
  input  logic    flags_enable,
  input  flags_t  flags_value,
  input  logic    rsv_enable,
  input  regind_t rsv_index,
  input  logic    flush,
  output regval_t flags_out
);

  localparam int FLAGS_IDX = flags_index(NR);
  localparam int PC_IDX    = pc_index(NR);

  regval_t       regs_q [NR];
  regval_t       regs_d [NR];
  logic [NR-1:0] written;

  regval_t rd_value_q [NRP];
  logic    rd_valid_q;

  logic    any_rd;
  logic    fb_hit   [NRP];
  regval_t fb_val   [NRP];
  logic    wt_hit   [NRP];
  regval_t wt_val   [NRP];
  regval_t arr_val  [NRP];
  regval_t resolved [NRP];
  logic    bypass   [NRP];

  // Next array contents; r0 and the PC slot are never written, out-of-range upper targets are dropped.
  always_comb begin
    regs_d  = regs_q;
    written = '0;
    for (int r = 1; r < NR; r++) begin
      if (r != PC_IDX) begin
        if (wr_enable && int'(wr_index) == r) begin
          regs_d[r]  = wr_value;
          written[r] = 1'b1;
        end
        if (wr_enable && wr_has_upper && int'(wr_index) + 1 == r) begin
          regs_d[r]  = wr_upper_value;
          written[r] = 1'b1;
        end
      end
    end
    if (flags_enable) begin
      regs_d[FLAGS_IDX][3:0] = flags_value;
      written[FLAGS_IDX]     = 1'b1;
    end
  end

  // Per-port read resolution: lowest-numbered feedback source wins, then write-through, then array.
  always_comb begin
    any_rd = 1'b0;
    for (int p = 0; p < NRP; p++) begin
      any_rd     = any_rd | rd_enable[p];
      fb_hit[p]  = 1'b0;
      fb_val[p]  = '0;
      wt_hit[p]  = 1'b0;
      wt_val[p]  = '0;
      arr_val[p] = '0;
      for (int s = NFB - 1; s >= 0; s--) begin
        if (fb_is_valid[s] && fb_index[s] == rd_index[p]) begin
          fb_hit[p] = 1'b1;
          fb_val[p] = fb_value[s];
        end else if (fb_is_valid[s] && fb_has_upper[s] &&
                     int'(fb_index[s]) + 1 == int'(rd_index[p])) begin
          fb_hit[p] = 1'b1;
          fb_val[p] = fb_upper_value[s];
        end
      end
      for (int r = 0; r < NR; r++) begin
        if (int'(rd_index[p]) == r) begin
          arr_val[p] = regs_q[r];
          wt_hit[p]  = written[r];
          wt_val[p]  = regs_d[r];
        end
      end
      resolved[p] = resolve_read(rd_index[p], pc, fb_hit[p], fb_val[p],
                                 wt_hit[p], wt_val[p], arr_val[p], NR);
      bypass[p]   = (fb_hit[p] || wt_hit[p]) && rd_index[p] != '0;
    end
  end

  register_bank_scoreboard #(.NR(NR), .NRP(NRP)) u_scoreboard (
    .clock          (clock),
    .reset_n        (reset_n),
    .wr_enable_i    (wr_enable),
    .wr_index_i     (wr_index),
    .wr_has_upper_i (wr_has_upper),
    .rsv_enable_i   (rsv_enable),
    .rsv_index_i    (rsv_index),
    .flush_i        (flush),
    .rd_enable_i    (rd_enable),
    .rd_index_i     (rd_index),
    .bypass_i       (bypass),
    .hold_o         (hold)
  );

  // Register array and read-port output registers; read ports freeze while hold is high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the array is built from flops, not RAM, so clearing it on reset is legal and intended.
      for (int r = 0; r < NR; r++) regs_q[r] <= '0;
      for (int p = 0; p < NRP; p++) rd_value_q[p] <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      if (!hold) begin
        rd_value_q <= resolved;
        rd_valid_q <= any_rd;
      end else begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  assign rd_value  = rd_value_q;
  assign rd_valid  = rd_valid_q;
  assign flags_out = regs_q[FLAGS_IDX];

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank (NR=32, NRP=2, NFB=2): Flags=r31, PC=r30.
module tb_register_bank;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] pc;
  logic        rd_enable      [2];
  logic [4:0]  rd_index       [2];
  logic [31:0] rd_value       [2];
  logic        rd_valid;
  logic        hold;
  logic        fb_is_valid    [2];
  logic [4:0]  fb_index       [2];
  logic [31:0] fb_value       [2];
  logic        fb_has_upper   [2];
  logic [31:0] fb_upper_value [2];
  logic        wr_enable;
  logic [4:0]  wr_index;
  logic [31:0] wr_value;
  logic        wr_has_upper;
  logic [31:0] wr_upper_value;
  logic        flags_enable;
  logic [3:0]  flags_value;
  logic        rsv_enable;
  logic [4:0]  rsv_index;
  logic        flush;
  logic [31:0] flags_out;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          port;
    logic [31:0] value;
    string       name;
  } exp_t;
  exp_t exp_q[$];

  always #5 clock = ~clock;

  register_bank #(.NR(32), .NRP(2), .NFB(2)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .pc             (pc),
    .rd_enable      (rd_enable),
    .rd_index       (rd_index),
    .rd_value       (rd_value),
    .rd_valid       (rd_valid),
    .hold           (hold),
    .fb_is_valid    (fb_is_valid),
    .fb_index       (fb_index),
    .fb_value       (fb_value),
    .fb_has_upper   (fb_has_upper),
    .fb_upper_value (fb_upper_value),
    .wr_enable      (wr_enable),
    .wr_index       (wr_index),
    .wr_value       (wr_value),
    .wr_has_upper   (wr_has_upper),
    .wr_upper_value (wr_upper_value),
    .flags_enable   (flags_enable),
    .flags_value    (flags_value),
    .rsv_enable     (rsv_enable),
    .rsv_index      (rsv_index),
    .flush          (flush),
    .flags_out      (flags_out)
  );

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog expired");
  end

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      rd_enable[p] = 1'b0;
      rd_index[p]  = '0;
      fb_is_valid[p] = 1'b0;
      fb_index[p] = '0;
      fb_value[p] = '0;
      fb_has_upper[p] = 1'b0;
      fb_upper_value[p] = '0;
    end
    wr_enable = 1'b0; wr_index = '0; wr_value = '0;
    wr_has_upper = 1'b0; wr_upper_value = '0;
    flags_enable = 1'b0; flags_value = '0;
    rsv_enable = 1'b0; rsv_index = '0; flush = 1'b0;
  endtask

  // Step one clock; inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic write(input int idx, input logic [31:0] val);
    wr_enable = 1'b1; wr_index = 5'(idx); wr_value = val;
  endtask

  task automatic read_req(input int p, input int idx, input logic [31:0] expv, input string nm);
    rd_enable[p] = 1'b1;
    rd_index[p]  = 5'(idx);
    exp_q.push_back('{port: p, value: expv, name: nm});
  endtask

  task automatic check_hold(input logic expv, input string nm);
    #1;
    n_checks++;
    if (hold !== expv) begin
      n_errors++;
      $display("FAIL %s: hold=%b, required %b", nm, hold, expv);
    end
  endtask

  // Clock once, then pop every queued expectation against the registered outputs.
  task automatic collect();
    cycle();
    n_checks++;
    if (rd_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL rd_valid_after_read: rd_valid=%b, required 1", rd_valid);
    end
    while (exp_q.size() > 0) begin
      exp_t e = exp_q.pop_front();
      n_checks++;
      if (rd_value[e.port] !== e.value) begin
        n_errors++;
        $display("FAIL %s: port%0d rd_value=0x%08h, required 0x%08h",
                 e.name, e.port, rd_value[e.port], e.value);
      end
    end
    idle();
  endtask

  task automatic check_flags(input logic [31:0] expv, input string nm);
    n_checks++;
    if (flags_out !== expv) begin
      n_errors++;
      $display("FAIL %s: flags_out=0x%08h, required 0x%08h", nm, flags_out, expv);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    pc = 32'h40;
    #12;
    n_checks++;
    if (rd_valid !== 1'b0 || hold !== 1'b0 || rd_value[0] !== '0 || rd_value[1] !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: valid=%b hold=%b v0=0x%08h v1=0x%08h, required 0 0 0 0",
               rd_valid, hold, rd_value[0], rd_value[1]);
    end
    check_flags(32'h0, "reset_flags");
    @(negedge clock);
    reset_n = 1'b1;
    cycle();
  endtask

  task automatic test_basic_rw();
    write(5, 32'h1234);
    cycle();
    idle();
    read_req(0, 5, 32'h1234, "read_r5");
    read_req(1, 0, 32'h0, "read_r0");
    collect();
    read_req(0, 30, 32'h40, "read_pc");
    write(6, 32'h55);
    read_req(1, 6, 32'h55, "write_through_r6");
    collect();
    write(0, 32'hFFFF);
    read_req(0, 0, 32'h0, "r0_write_dropped");
    collect();
  endtask

  task automatic test_forwarding();
    write(3, 32'hC);
    cycle();
    idle();
    fb_is_valid[0] = 1'b1; fb_index[0] = 5'd3; fb_value[0] = 32'hA;
    fb_is_valid[1] = 1'b1; fb_index[1] = 5'd3; fb_value[1] = 32'hB;
    read_req(0, 3, 32'hA, "fb0_priority");
    collect();
    fb_is_valid[1] = 1'b1; fb_index[1] = 5'd3; fb_value[1] = 32'hB;
    read_req(0, 3, 32'hB, "fb1_only");
    collect();
    read_req(0, 3, 32'hC, "array_after_fb");
    collect();
    fb_is_valid[0] = 1'b1; fb_index[0] = 5'd3; fb_value[0] = 32'h77;
    fb_has_upper[0] = 1'b1; fb_upper_value[0] = 32'hD;
    read_req(0, 4, 32'hD, "fb0_upper");
    read_req(1, 3, 32'h77, "fb0_lower");
    collect();
  endtask

  task automatic test_paired_write();
    write(30, 32'h1);
    wr_has_upper = 1'b1; wr_upper_value = 32'h2;
    cycle();
    idle();
    check_flags(32'h2, "paired_30_flags");
    write(29, 32'h29);
    wr_has_upper = 1'b1; wr_upper_value = 32'h30;
    cycle();
    idle();
    check_flags(32'h2, "paired_29_flags_untouched");
    read_req(0, 29, 32'h29, "paired_29_lower");
    read_req(1, 30, 32'h40, "pc_still_pc");
    collect();
    write(31, 32'h31);
    wr_has_upper = 1'b1; wr_upper_value = 32'h99;
    cycle();
    idle();
    check_flags(32'h31, "paired_31_no_wrap");
    read_req(0, 0, 32'h0, "r0_after_wrap");
    collect();
    write(31, 32'hABCD_EF12);
    flags_enable = 1'b1; flags_value = 4'h5;
    cycle();
    idle();
    check_flags(32'hABCD_EF15, "flags_merge_write");
    flags_enable = 1'b1; flags_value = 4'h3;
    cycle();
    idle();
    check_flags(32'hABCD_EF13, "flags_only");
    read_req(0, 31, 32'hABCD_EF13, "read_flags_reg");
    collect();
  endtask

  task automatic test_hold();
    rsv_enable = 1'b1; rsv_index = 5'd7;
    cycle();
    idle();
    read_req(0, 5, 32'h1234, "pre_hold_r5");
    collect();
    rd_enable[0] = 1'b1; rd_index[0] = 5'd7;
    check_hold(1'b1, "hold_on_pending_r7");
    cycle();
    n_checks++;
    if (rd_valid !== 1'b0 || rd_value[0] !== 32'h1234) begin
      n_errors++;
      $display("FAIL held_output: valid=%b v0=0x%08h, required 0 0x00001234", rd_valid, rd_value[0]);
    end
    write(7, 32'h99);
    read_req(0, 7, 32'h99, "write_resolves_r7");
    check_hold(1'b0, "hold_released_by_write");
    collect();
    read_req(0, 7, 32'h99, "r7_after_clear");
    check_hold(1'b0, "pending7_cleared");
    collect();
    rsv_enable = 1'b1; rsv_index = 5'd11;
    write(11, 32'h11);
    cycle();
    idle();
    rd_enable[1] = 1'b1; rd_index[1] = 5'd11;
    check_hold(1'b1, "rsv_beats_write");
    write(11, 32'h22);
    read_req(1, 11, 32'h22, "r11_resolved");
    collect();
  endtask

  task automatic test_flush();
    rsv_enable = 1'b1; rsv_index = 5'd9; flush = 1'b1;
    cycle();
    idle();
    read_req(0, 9, 32'h0, "r9_after_flush");
    check_hold(1'b0, "flush_beats_rsv");
    collect();
    rsv_enable = 1'b1; rsv_index = 5'd10;
    cycle();
    idle();
    flush = 1'b1;
    cycle();
    idle();
    read_req(1, 10, 32'h0, "r10_after_flush");
    check_hold(1'b0, "flush_clears_pending");
    collect();
  endtask

  task automatic test_reset_mid_hold();
    write(1, 32'h77);
    cycle();
    idle();
    read_req(0, 1, 32'h77, "r1_before_reset");
    rsv_enable = 1'b1; rsv_index = 5'd1;
    collect();
    rd_enable[0] = 1'b1; rd_index[0] = 5'd1;
    check_hold(1'b1, "hold_before_reset");
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (rd_valid !== 1'b0 || rd_value[0] !== '0 || hold !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: valid=%b v0=0x%08h hold=%b, required 0 0 0",
               rd_valid, rd_value[0], hold);
    end
    idle();
    @(negedge clock);
    reset_n = 1'b1;
    cycle();
    read_req(0, 1, 32'h0, "r1_after_reset");
    collect();
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_forwarding();
    test_paired_write();
    test_hold();
    test_flush();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
